// File: rtl/tlp_det_pkg.sv
// Shared definitions for the TLP frame detector: K-code values, FSM state
// type and symbol classification.
package tlp_det_pkg;

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;

  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_DROP = 2'd2
  } det_state_e;

  typedef enum logic [2:0] {
    SYM_DATA = 3'd0,
    SYM_STP  = 3'd1,
    SYM_END  = 3'd2,
    SYM_EDB  = 3'd3,
    SYM_BADK = 3'd4
  } sym_e;

  // Map a received symbol onto the framing alphabet; unknown K codes are illegal.
  function automatic sym_e classify(input logic is_k, input logic [7:0] b);
    sym_e s;
    if (!is_k) begin
      s = SYM_DATA;
    end else begin
      case (b)
        K_STP:   s = SYM_STP;
        K_END:   s = SYM_END;
        K_EDB:   s = SYM_EDB;
        default: s = SYM_BADK;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, cleared only by the asynchronous active-low reset.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Advance on inc, holding at all-ones.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/tlp_frame_detector.sv
// TLP frame detector: tracks STP..END/EDB framing on a symbol stream, reports
// good/bad/nullified frames with their byte count, and drives the in-flight
// TLP up/down counter. Optional pulse statistics under TLP_DET_STATS_EN.
module tlp_frame_detector
  import tlp_det_pkg::*;
#(
  parameter int unsigned MIN_LEN = 18,
  parameter int unsigned MAX_LEN = 4120,
  parameter int unsigned LEN_W   = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_k,
  input  logic              consume,
  output logic              tlp_active,
  output logic              tlp_good,
  output logic              tlp_bad,
  output logic              tlp_null,
  output logic [LEN_W-1:0]  tlp_len,
  output logic              cnt_enable,
  output logic              cnt_up,
  output logic [STAT_W-1:0] good_cnt,
  output logic [STAT_W-1:0] bad_cnt
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);

  det_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] tlp_len_q, tlp_len_d;
  logic             tlp_active_q, tlp_active_d;
  logic             tlp_good_q, tlp_good_d;
  logic             tlp_bad_q, tlp_bad_d;
  logic             tlp_null_q, tlp_null_d;
  logic             cnt_enable_q, cnt_enable_d;
  logic             cnt_up_q, cnt_up_d;

  sym_e             sym;
  logic [LEN_W-1:0] sat_len;

  assign sym     = classify(in_k, in_data);
  assign sat_len = (len_q > LEN_MAX) ? LEN_MAX : len_q;

  // Framing FSM next-state, length tracking and closing-pulse generation.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    tlp_len_d    = tlp_len_q;
    tlp_good_d   = 1'b0;
    tlp_bad_d    = 1'b0;
    tlp_null_d   = 1'b0;

    if (in_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (sym == SYM_STP) begin
            state_d = ST_BODY;
            len_d   = '0;
          end
        end

        ST_BODY: begin
          case (sym)
            SYM_DATA: begin
              if (len_q == LEN_MAX) begin
                state_d = ST_DROP;
              end else begin
                len_d = len_q + LEN_W'(1);
              end
            end
            SYM_STP: begin
              tlp_bad_d = 1'b1;
              tlp_len_d = sat_len;
              len_d     = '0;
            end
            SYM_END: begin
              tlp_good_d = (len_q >= LEN_MIN);
              tlp_bad_d  = (len_q < LEN_MIN);
              tlp_len_d  = sat_len;
              state_d    = ST_IDLE;
              len_d      = '0;
            end
            SYM_EDB: begin
              tlp_null_d = 1'b1;
              tlp_len_d  = sat_len;
              state_d    = ST_IDLE;
              len_d      = '0;
            end
            default: begin
              tlp_bad_d = 1'b1;
              tlp_len_d = sat_len;
              state_d   = ST_IDLE;
              len_d     = '0;
            end
          endcase
        end

        ST_DROP: begin
          if (sym == SYM_STP) begin
            tlp_bad_d = 1'b1;
            tlp_len_d = sat_len;
            state_d   = ST_BODY;
            len_d     = '0;
          end else if (sym != SYM_DATA) begin
            tlp_bad_d = 1'b1;
            tlp_len_d = sat_len;
            state_d   = ST_IDLE;
            len_d     = '0;
          end
        end

        default: begin
          state_d = ST_IDLE;
          len_d   = '0;
        end
      endcase
    end
  end

  // Open-frame flag and in-flight counter control, independent of in_valid.
  always_comb begin
    tlp_active_d = (state_d != ST_IDLE);
    cnt_enable_d = tlp_good_d ^ consume;
    cnt_up_d     = tlp_good_d & ~consume;
  end

  // State, length and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      tlp_len_q    <= '0;
      tlp_active_q <= 1'b0;
      tlp_good_q   <= 1'b0;
      tlp_bad_q    <= 1'b0;
      tlp_null_q   <= 1'b0;
      cnt_enable_q <= 1'b0;
      cnt_up_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      tlp_len_q    <= tlp_len_d;
      tlp_active_q <= tlp_active_d;
      tlp_good_q   <= tlp_good_d;
      tlp_bad_q    <= tlp_bad_d;
      tlp_null_q   <= tlp_null_d;
      cnt_enable_q <= cnt_enable_d;
      cnt_up_q     <= cnt_up_d;
    end
  end

  assign tlp_active = tlp_active_q;
  assign tlp_good   = tlp_good_q;
  assign tlp_bad    = tlp_bad_q;
  assign tlp_null   = tlp_null_q;
  assign tlp_len    = tlp_len_q;
  assign cnt_enable = cnt_enable_q;
  assign cnt_up     = cnt_up_q;

`ifdef TLP_DET_STATS_EN
  sat_counter #(.WIDTH(STAT_W)) u_good_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (tlp_good_q),
    .count (good_cnt)
  );

  sat_counter #(.WIDTH(STAT_W)) u_bad_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (tlp_bad_q),
    .count (bad_cnt)
  );
`else
  assign good_cnt = '0;
  assign bad_cnt  = '0;
`endif

endmodule

// File: tb/tb_tlp_frame_detector.sv
// Bench for tlp_frame_detector: directed framing scenarios plus randomized
// symbol streams compared cycle by cycle against a frame-level model.
module tb_tlp_frame_detector;

  localparam int unsigned MIN_LEN = 18;
  localparam int unsigned MAX_LEN = 4120;
  localparam int unsigned LEN_W   = 13;

  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] ENDK = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_k;
  logic             consume;
  logic             tlp_active, tlp_good, tlp_bad, tlp_null;
  logic [LEN_W-1:0] tlp_len;
  logic             cnt_enable, cnt_up;
  logic [15:0]      good_cnt, bad_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Frame-level reference: is a frame open, how many data bytes it has seen
  // (uncapped), and the expected registered outputs.
  bit m_open;
  int m_bytes;
  int e_len;
  bit e_good, e_bad, e_null, e_act, e_en, e_up;
  int e_gcnt, e_bcnt;

  logic [7:0] kcodes [6];

  tlp_frame_detector #(
    .MIN_LEN (MIN_LEN),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_k       (in_k),
    .consume    (consume),
    .tlp_active (tlp_active),
    .tlp_good   (tlp_good),
    .tlp_bad    (tlp_bad),
    .tlp_null   (tlp_null),
    .tlp_len    (tlp_len),
    .cnt_enable (cnt_enable),
    .cnt_up     (cnt_up),
    .good_cnt   (good_cnt),
    .bad_cnt    (bad_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit rc();
    return ($urandom_range(0, 3) == 0);
  endfunction

  function automatic logic [7:0] rbyte();
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic model_reset();
    m_open  = 1'b0;
    m_bytes = 0;
    e_len   = 0;
    e_good  = 1'b0;
    e_bad   = 1'b0;
    e_null  = 1'b0;
    e_act   = 1'b0;
    e_en    = 1'b0;
    e_up    = 1'b0;
    e_gcnt  = 0;
    e_bcnt  = 0;
  endtask

  // Apply one symbol to the model; a frame overflows once it holds more than MAX_LEN bytes.
  task automatic model_step(input bit v, input logic [7:0] d, input bit k, input bit c);
    int capped;
    // Statistics trail the pulses by one cycle.
    if (e_good && e_gcnt < 65535) e_gcnt++;
    if (e_bad && e_bcnt < 65535) e_bcnt++;
    e_good = 1'b0;
    e_bad  = 1'b0;
    e_null = 1'b0;
    capped = (m_bytes > int'(MAX_LEN)) ? int'(MAX_LEN) : m_bytes;
    if (v) begin
      if (k && d == STP) begin
        if (m_open) begin
          e_bad = 1'b1;
          e_len = capped;
        end
        m_open  = 1'b1;
        m_bytes = 0;
      end else if (m_open) begin
        if (!k) begin
          m_bytes++;
        end else begin
          e_len = capped;
          if (d == ENDK) begin
            if (m_bytes > int'(MAX_LEN) || m_bytes < int'(MIN_LEN)) e_bad = 1'b1;
            else e_good = 1'b1;
          end else if (d == EDB) begin
            if (m_bytes > int'(MAX_LEN)) e_bad = 1'b1;
            else e_null = 1'b1;
          end else begin
            e_bad = 1'b1;
          end
          m_open = 1'b0;
        end
      end
    end
    e_act = m_open;
    e_en  = (e_good != c);
    e_up  = e_good && !c;
  endtask

  // Drive one symbol, clock it in, then compare every output with the model.
  task automatic step(input bit v, input logic [7:0] d, input bit k, input bit c);
    logic [31:0] obs, exp, cobs, cexp;
    in_valid = v;
    in_data  = d;
    in_k     = k;
    consume  = c;
    @(posedge clk);
    #1;
    model_step(v, d, k, c);
    obs = 32'({tlp_active, tlp_good, tlp_bad, tlp_null, cnt_enable, cnt_up, tlp_len});
    exp = 32'({e_act, e_good, e_bad, e_null, e_en, e_up, LEN_W'(e_len)});
    chk("outputs", obs, exp);
    cobs = {good_cnt, bad_cnt};
`ifdef TLP_DET_STATS_EN
    cexp = {16'(e_gcnt), 16'(e_bcnt)};
`else
    cexp = 32'h0;
`endif
    chk("stats", cobs, cexp);
  endtask

  task automatic send_frame(input int n, input logic [7:0] closer, input bit c_last);
    step(1'b1, STP, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) step(1'b1, rbyte(), 1'b0, 1'b0);
    step(1'b1, closer, 1'b1, c_last);
  endtask

  initial begin
    int n, r;
    kcodes[0] = STP;
    kcodes[1] = ENDK;
    kcodes[2] = EDB;
    kcodes[3] = 8'h1C;
    kcodes[4] = 8'hBC;
    kcodes[5] = 8'hF7;

    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_k     = 1'b0;
    consume  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'({tlp_active, tlp_good, tlp_bad, tlp_null, cnt_enable, cnt_up, tlp_len}), 32'h0);
    reset = 1'b1;

    // Legal 20-byte frame.
    send_frame(20, ENDK, 1'b0);
    chk("good20_pulse", 32'({tlp_good, tlp_bad, tlp_null}), 32'b100);
    chk("good20_len", 32'(tlp_len), 32'd20);
    chk("good20_cnt", 32'({cnt_enable, cnt_up}), 32'b11);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("len_hold", 32'(tlp_len), 32'd20);

    // Runt frame.
    send_frame(5, ENDK, 1'b0);
    chk("runt_pulse", 32'({tlp_good, tlp_bad}), 32'b01);
    chk("runt_len", 32'(tlp_len), 32'd5);
    chk("runt_cnt", 32'(cnt_enable), 32'd0);

    // Nullified frame.
    send_frame(30, EDB, 1'b0);
    chk("null_pulse", 32'({tlp_good, tlp_bad, tlp_null}), 32'b001);
    chk("null_len", 32'(tlp_len), 32'd30);
    chk("null_cnt", 32'(cnt_enable), 32'd0);

    // Frame of exactly MAX_LEN bytes is still good.
    send_frame(MAX_LEN, ENDK, 1'b0);
    chk("maxlen_good", 32'(tlp_good), 32'd1);
    chk("maxlen_len", 32'(tlp_len), 32'(MAX_LEN));

    // Oversize frame enters DROP and closes bad at MAX_LEN.
    step(1'b1, STP, 1'b1, 1'b0);
    for (int i = 0; i < int'(MAX_LEN) + 3; i++) step(1'b1, rbyte(), 1'b0, 1'b0);
    chk("drop_active", 32'(tlp_active), 32'd1);
    step(1'b1, ENDK, 1'b1, 1'b0);
    chk("drop_pulse", 32'({tlp_good, tlp_bad}), 32'b01);
    chk("drop_len", 32'(tlp_len), 32'(MAX_LEN));

    // Good END coinciding with consume, then consume alone.
    send_frame(20, ENDK, 1'b1);
    chk("good_consume_pulse", 32'(tlp_good), 32'd1);
    chk("good_consume_cnt", 32'(cnt_enable), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("consume_only", 32'({cnt_enable, cnt_up}), 32'b10);

    // STP inside an open frame closes it bad and reopens.
    step(1'b1, STP, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, rbyte(), 1'b0, 1'b0);
    step(1'b1, STP, 1'b1, 1'b0);
    chk("restart_bad", 32'({tlp_bad, tlp_active, tlp_len}), 32'({1'b1, 1'b1, LEN_W'(7)}));
    step(1'b1, 8'hBC, 1'b1, 1'b0);
    chk("badk_bad", 32'({tlp_bad, tlp_active}), 32'b10);

    // Reset in the middle of a frame: nothing emitted, then a legal 18-byte frame.
    step(1'b1, STP, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, rbyte(), 1'b0, 1'b0);
    reset = 1'b0;
    #2;
    chk("midreset_outs", 32'({tlp_active, tlp_good, tlp_bad, tlp_null, cnt_enable, cnt_up, tlp_len}), 32'h0);
    in_valid = 1'b1;
    in_data  = ENDK;
    in_k     = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_nopulse", 32'({tlp_good, tlp_bad, tlp_null, tlp_active}), 32'h0);
    in_valid = 1'b0;
    reset    = 1'b1;
    model_reset();
    send_frame(18, ENDK, 1'b0);
    chk("post_reset_good", 32'(tlp_good), 32'd1);
    chk("post_reset_len", 32'(tlp_len), 32'd18);

    // Randomized streams with gaps, stalls, stray K codes and random consume.
    for (int f = 0; f < 250; f++) begin
      n = int'($urandom_range(0, 3));
      for (int g = 0; g < n; g++)
        step(bit'($urandom_range(0, 1)), rbyte(), ($urandom_range(0, 7) == 0), rc());
      step(1'b1, STP, 1'b1, rc());
      n = int'($urandom_range(0, 40));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 29) == 0)
          step(1'b1, kcodes[$urandom_range(0, 5)], 1'b1, rc());
        else
          step(($urandom_range(0, 4) != 0), rbyte(), 1'b0, rc());
      end
      r = int'($urandom_range(0, 9));
      if (r < 7) step(1'b1, ENDK, 1'b1, rc());
      else if (r < 9) step(1'b1, EDB, 1'b1, rc());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
